// File: rtl/fb_sched_pkg.sv
// Shared bank types and address defaults for the SDRAM triple-buffer scheduler.
package fb_sched_pkg;

    typedef logic [1:0] bank_t;

    localparam bank_t BANK0 = 2'd0;
    localparam bank_t BANK1 = 2'd1;
    localparam bank_t BANK2 = 2'd2;

    localparam int          DEF_ADDR_W       = 23;
    localparam logic [22:0] DEF_BANK_STRIDE  = 23'h080000;
    localparam logic [22:0] DEF_PORT2_OFFSET = 23'h200000;
    localparam int          DEF_FRAME_WORDS  = 307200;

    // For two distinct banks in 0..2 the remaining one is 3 - a - b.
    function automatic bank_t third_bank(input bank_t a, input bank_t b);
        return bank_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a previous-value register producing rise/fall pulses.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       s1_reg;
    logic       s2_reg;
    logic       prev_reg;
    logic [1:0] prime_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            prev_reg  <= 1'b0;
            prime_reg <= 2'd0;
        end else begin
            s1_reg   <= din;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
            if (prime_reg != 2'd3) begin
                prime_reg <= prime_reg + 2'd1;
            end
        end
    end

    // Edges are suppressed until the pipeline holds real samples, so a level
    // already present at reset release is never mistaken for a transition.
    assign level = s2_reg;
    assign rise  = (prime_reg == 2'd3) &  s2_reg & ~prev_reg;
    assign fall  = (prime_reg == 2'd3) & ~s2_reg &  prev_reg;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: hands SDRAM banks to the camera writer and VGA
// reader, drives port addresses with LOAD strobes, and keeps frame statistics.
module frame_bank_scheduler
    import fb_sched_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BANK_STRIDE  = DEF_BANK_STRIDE,
    parameter logic [ADDR_W-1:0] PORT2_OFFSET = DEF_PORT2_OFFSET,
    parameter int                FRAME_WORDS  = DEF_FRAME_WORDS,
    parameter int                LOAD_CYCLES  = 4,
    parameter int                CNT_W        = 16
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iCAP_FVAL,
    input  logic              iVGA_VS,
    input  logic              iFREEZE,
    output logic [ADDR_W-1:0] oWR1_ADDR,
    output logic [ADDR_W-1:0] oWR1_MAX_ADDR,
    output logic [ADDR_W-1:0] oWR2_ADDR,
    output logic [ADDR_W-1:0] oWR2_MAX_ADDR,
    output logic [ADDR_W-1:0] oRD1_ADDR,
    output logic [ADDR_W-1:0] oRD1_MAX_ADDR,
    output logic [ADDR_W-1:0] oRD2_ADDR,
    output logic [ADDR_W-1:0] oRD2_MAX_ADDR,
    output logic              oWR_LOAD,
    output logic              oRD_LOAD,
    output logic [1:0]        oWR_BANK,
    output logic [1:0]        oRD_BANK,
    output logic              oDISP_VALID,
    output logic [CNT_W-1:0]  oWR_FRAMES,
    output logic [CNT_W-1:0]  oRD_FRAMES,
    output logic [CNT_W-1:0]  oDROPPED
);

    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES + 1) : 1;

    function automatic logic [ADDR_W-1:0] bank_base(input bank_t b);
        return ADDR_W'(b) * BANK_STRIDE;
    endfunction

    logic cap_level, cap_rise, cap_fall;
    logic vs_level, vs_rise, vs_fall;
    logic fz_level, fz_rise, fz_fall;
    logic unused_sig;

    sync_edge_det u_sync_fval (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .din   (iCAP_FVAL),
        .level (cap_level),
        .rise  (cap_rise),
        .fall  (cap_fall)
    );

    sync_edge_det u_sync_vs (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .din   (iVGA_VS),
        .level (vs_level),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    sync_edge_det u_sync_freeze (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .din   (iFREEZE),
        .level (fz_level),
        .rise  (fz_rise),
        .fall  (fz_fall)
    );

    assign unused_sig = &{1'b0, cap_level, vs_level, vs_rise, fz_rise, fz_fall};

    bank_t            w_bank_reg, w_bank_next;
    bank_t            r_bank_reg, r_bank_next;
    bank_t            rdy_bank_reg, rdy_bank_next;
    logic             rdy_valid_reg, rdy_valid_next;
    logic             wr_active_reg, wr_active_next;
    logic             disp_valid_reg, disp_valid_next;
    logic [CNT_W-1:0] wr_frames_reg, wr_frames_next;
    logic [CNT_W-1:0] rd_frames_reg, rd_frames_next;
    logic [CNT_W-1:0] dropped_reg, dropped_next;
    logic             wr_end;
    logic [1:0]       load_evt;

    always_comb begin
        w_bank_next     = w_bank_reg;
        r_bank_next     = r_bank_reg;
        rdy_bank_next   = rdy_bank_reg;
        rdy_valid_next  = rdy_valid_reg;
        wr_active_next  = wr_active_reg;
        disp_valid_next = disp_valid_reg;
        wr_frames_next  = wr_frames_reg;
        rd_frames_next  = rd_frames_reg;
        dropped_next    = dropped_reg;
        wr_end          = cap_fall & wr_active_reg;

        if (cap_rise) begin
            wr_active_next = 1'b1;
        end

        if (wr_end) begin
            wr_active_next = 1'b0;
            wr_frames_next = wr_frames_reg + CNT_W'(1);
            if (rdy_valid_reg && (dropped_reg != '1)) begin
                dropped_next = dropped_reg + CNT_W'(1);
            end
            if (vs_fall && !fz_level) begin
                // Simultaneous completion and vsync: the reader takes the
                // fresh frame directly and the writer moves into the old display bank.
                r_bank_next     = w_bank_reg;
                w_bank_next     = r_bank_reg;
                rdy_valid_next  = 1'b0;
                disp_valid_next = 1'b1;
                rd_frames_next  = rd_frames_reg + CNT_W'(1);
            end else begin
                rdy_bank_next  = w_bank_reg;
                rdy_valid_next = 1'b1;
                w_bank_next    = third_bank(w_bank_reg, r_bank_reg);
            end
        end else if (vs_fall && !fz_level && rdy_valid_reg) begin
            r_bank_next     = rdy_bank_reg;
            rdy_valid_next  = 1'b0;
            disp_valid_next = 1'b1;
            rd_frames_next  = rd_frames_reg + CNT_W'(1);
        end

        // The reader is rewound on every vsync, swapped or not.
        load_evt = {vs_fall, wr_end};
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            w_bank_reg     <= BANK0;
            r_bank_reg     <= BANK2;
            rdy_bank_reg   <= BANK1;
            rdy_valid_reg  <= 1'b0;
            wr_active_reg  <= 1'b0;
            disp_valid_reg <= 1'b0;
            wr_frames_reg  <= '0;
            rd_frames_reg  <= '0;
            dropped_reg    <= '0;
        end else begin
            w_bank_reg     <= w_bank_next;
            r_bank_reg     <= r_bank_next;
            rdy_bank_reg   <= rdy_bank_next;
            rdy_valid_reg  <= rdy_valid_next;
            wr_active_reg  <= wr_active_next;
            disp_valid_reg <= disp_valid_next;
            wr_frames_reg  <= wr_frames_next;
            rd_frames_reg  <= rd_frames_next;
            dropped_reg    <= dropped_next;
        end
    end

    // Forces both LOAD pulses on the first edge after reset release.
    logic       init_reg;
    logic [1:0] load_out;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            init_reg <= 1'b1;
        end else begin
            init_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_load
            logic           pulse_reg;
            logic [LCW-1:0] cnt_reg;

            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else if (load_evt[gi] || init_reg) begin
                    pulse_reg <= 1'b1;
                    cnt_reg   <= LCW'(LOAD_CYCLES - 1);
                end else if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - LCW'(1);
                end else begin
                    pulse_reg <= 1'b0;
                end
            end

            assign load_out[gi] = pulse_reg;
        end

        // Ports 0/1 are WR1/WR2, ports 2/3 are RD1/RD2.
        for (gi = 0; gi < 4; gi++) begin : g_port
            localparam logic [ADDR_W-1:0] OFS = ((gi % 2) == 1) ? PORT2_OFFSET : '0;
            localparam bank_t             RST_BANK = (gi < 2) ? BANK0 : BANK2;

            logic [ADDR_W-1:0] addr_reg;
            logic [ADDR_W-1:0] max_reg;
            logic [ADDR_W-1:0] addr_next;

            assign addr_next = bank_base((gi < 2) ? w_bank_next : r_bank_next) + OFS;

            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    addr_reg <= bank_base(RST_BANK) + OFS;
                    max_reg  <= bank_base(RST_BANK) + OFS + ADDR_W'(FRAME_WORDS);
                end else begin
                    addr_reg <= addr_next;
                    max_reg  <= addr_next + ADDR_W'(FRAME_WORDS);
                end
            end
        end
    endgenerate

    assign oWR1_ADDR     = g_port[0].addr_reg;
    assign oWR1_MAX_ADDR = g_port[0].max_reg;
    assign oWR2_ADDR     = g_port[1].addr_reg;
    assign oWR2_MAX_ADDR = g_port[1].max_reg;
    assign oRD1_ADDR     = g_port[2].addr_reg;
    assign oRD1_MAX_ADDR = g_port[2].max_reg;
    assign oRD2_ADDR     = g_port[3].addr_reg;
    assign oRD2_MAX_ADDR = g_port[3].max_reg;

    assign oWR_LOAD    = load_out[0];
    assign oRD_LOAD    = load_out[1];
    assign oWR_BANK    = w_bank_reg;
    assign oRD_BANK    = r_bank_reg;
    assign oDISP_VALID = disp_valid_reg;
    assign oWR_FRAMES  = wr_frames_reg;
    assign oRD_FRAMES  = rd_frames_reg;
    assign oDROPPED    = dropped_reg;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Scoreboard bench: stimulus queues the expected state at each LOAD pulse start,
// a monitor pops and compares when a pulse begins.
module tb_frame_bank_scheduler;

    localparam int GAP = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fval;
    logic        vs;
    logic        freeze;
    logic [22:0] wr1_addr, wr1_max, wr2_addr, wr2_max;
    logic [22:0] rd1_addr, rd1_max, rd2_addr, rd2_max;
    logic        wr_load, rd_load;
    logic [1:0]  wr_bank, rd_bank;
    logic        disp_valid;
    logic [15:0] wr_frames, rd_frames, dropped;

    always #5 clk = ~clk;

    frame_bank_scheduler dut (
        .iCLK          (clk),
        .iRST_N        (rst_n),
        .iCAP_FVAL     (fval),
        .iVGA_VS       (vs),
        .iFREEZE       (freeze),
        .oWR1_ADDR     (wr1_addr),
        .oWR1_MAX_ADDR (wr1_max),
        .oWR2_ADDR     (wr2_addr),
        .oWR2_MAX_ADDR (wr2_max),
        .oRD1_ADDR     (rd1_addr),
        .oRD1_MAX_ADDR (rd1_max),
        .oRD2_ADDR     (rd2_addr),
        .oRD2_MAX_ADDR (rd2_max),
        .oWR_LOAD      (wr_load),
        .oRD_LOAD      (rd_load),
        .oWR_BANK      (wr_bank),
        .oRD_BANK      (rd_bank),
        .oDISP_VALID   (disp_valid),
        .oWR_FRAMES    (wr_frames),
        .oRD_FRAMES    (rd_frames),
        .oDROPPED      (dropped)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [1:0] w;
        logic [1:0] r;
        logic       disp;
        int         wrf;
        int         rdf;
        int         drop;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   viol   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr, input logic rd, input int w, input int r,
                        input logic disp, input int wrf, input int rdf, input int drop);
        exp_t e;
        e.wr = wr; e.rd = rd; e.w = 2'(w); e.r = 2'(r);
        e.disp = disp; e.wrf = wrf; e.rdf = rdf; e.drop = drop;
        q.push_back(e);
        $display("queued: wr_load=%0b rd_load=%0b w=%0d r=%0d disp=%0b wrf=%0d rdf=%0d drop=%0d",
                 wr, rd, w, r, disp, wrf, rdf, drop);
    endtask

    // Full frame whose completion is expected to produce the given state.
    task automatic frame(input int w, input int r, input logic disp,
                         input int wrf, input int rdf, input int drop);
        fval = 1'b1;
        tick(GAP);
        push(1'b1, 1'b0, w, r, disp, wrf, rdf, drop);
        fval = 1'b0;
        tick(GAP);
    endtask

    task automatic vsync(input int w, input int r, input logic disp,
                         input int wrf, input int rdf, input int drop);
        push(1'b0, 1'b1, w, r, disp, wrf, rdf, drop);
        vs = 1'b0;
        tick(GAP);
        vs = 1'b1;
        tick(GAP);
    endtask

    task automatic monitor();
        logic        wr_p = 1'b0, rd_p = 1'b0;
        int          wr_w = 0, rd_w = 0;
        exp_t        e;
        logic [22:0] bw, br;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_p = 1'b0; rd_p = 1'b0; wr_w = 0; rd_w = 0;
            end else begin
                if (wr_bank == rd_bank || wr_bank == 2'd3 || rd_bank == 2'd3) viol++;
                if ((wr_load && !wr_p) || (rd_load && !rd_p)) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_load: got wr_load=%0b rd_load=%0b, required no pulse (t=%0t)",
                                 wr_load, rd_load, $time);
                    end else begin
                        e  = q.pop_front();
                        bw = 23'(e.w) * 23'h080000;
                        br = 23'(e.r) * 23'h080000;
                        $display("load event: wr_load=%0b rd_load=%0b w=%0d r=%0d disp=%0b wrf=%0d rdf=%0d drop=%0d",
                                 wr_load && !wr_p, rd_load && !rd_p, wr_bank, rd_bank, disp_valid,
                                 wr_frames, rd_frames, dropped);
                        chk("ev_wr_load", 32'(wr_load && !wr_p), 32'(e.wr));
                        chk("ev_rd_load", 32'(rd_load && !rd_p), 32'(e.rd));
                        chk("wr_bank", 32'(wr_bank), 32'(e.w));
                        chk("rd_bank", 32'(rd_bank), 32'(e.r));
                        chk("disp_valid", 32'(disp_valid), 32'(e.disp));
                        chk("wr_frames", 32'(wr_frames), e.wrf);
                        chk("rd_frames", 32'(rd_frames), e.rdf);
                        chk("dropped", 32'(dropped), e.drop);
                        chk("wr1_addr", 32'(wr1_addr), 32'(bw));
                        chk("wr2_addr", 32'(wr2_addr), 32'(bw + 23'h200000));
                        chk("wr1_max", 32'(wr1_max), 32'(bw + 23'h04B000));
                        chk("rd1_addr", 32'(rd1_addr), 32'(br));
                        chk("rd1_max", 32'(rd1_max), 32'(br + 23'h04B000));
                        chk("rd2_max", 32'(rd2_max), 32'(br + 23'h24B000));
                    end
                end
                if (wr_load) wr_w++;
                else if (wr_p) begin chk("wr_load_width", 32'(wr_w), 32'd4); wr_w = 0; end
                if (rd_load) rd_w++;
                else if (rd_p) begin chk("rd_load_width", 32'(rd_w), 32'd4); rd_w = 0; end
                wr_p = wr_load;
                rd_p = rd_load;
            end
        end
    endtask

    task automatic stimulus();
        rst_n = 1'b0; fval = 1'b0; vs = 1'b1; freeze = 1'b0;
        tick(3);
        chk("rst_wr_load", 32'(wr_load), 32'd0);
        chk("rst_rd_load", 32'(rd_load), 32'd0);
        chk("rst_wr1_addr", 32'(wr1_addr), 32'h000000);
        chk("rst_wr2_addr", 32'(wr2_addr), 32'h200000);
        chk("rst_rd1_addr", 32'(rd1_addr), 32'h100000);
        chk("rst_rd1_max", 32'(rd1_max), 32'h14B000);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        push(1'b1, 1'b1, 0, 2, 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        tick(GAP);

        // First frame, then first display swap.
        frame(1, 2, 1'b0, 1, 0, 0);
        vsync(1, 0, 1'b1, 1, 1, 0);

        // Completion and vsync on the same sampled edge.
        fval = 1'b1;
        tick(GAP);
        push(1'b1, 1'b1, 0, 1, 1'b1, 2, 2, 0);
        fval = 1'b0;
        vs   = 1'b0;
        tick(GAP);
        vs = 1'b1;
        tick(GAP);

        // Three frames without vsync: two drops, then the newest is shown.
        frame(2, 1, 1'b1, 3, 2, 0);
        frame(0, 1, 1'b1, 4, 2, 1);
        frame(2, 1, 1'b1, 5, 2, 2);
        vsync(2, 0, 1'b1, 5, 3, 2);

        // Frozen display across four frames and four vsyncs.
        freeze = 1'b1;
        tick(6);
        frame(1, 0, 1'b1, 6, 3, 2);
        vsync(1, 0, 1'b1, 6, 3, 2);
        frame(2, 0, 1'b1, 7, 3, 3);
        vsync(2, 0, 1'b1, 7, 3, 3);
        frame(1, 0, 1'b1, 8, 3, 4);
        vsync(1, 0, 1'b1, 8, 3, 4);
        frame(2, 0, 1'b1, 9, 3, 5);
        vsync(2, 0, 1'b1, 9, 3, 5);
        freeze = 1'b0;
        tick(6);
        vsync(2, 1, 1'b1, 9, 4, 5);

        // Reset in the middle of a frame; the partial frame is discarded.
        fval = 1'b1;
        tick(GAP);
        rst_n = 1'b0;
        tick(3);
        chk("midrst_wr_load", 32'(wr_load), 32'd0);
        chk("midrst_rd_bank", 32'(rd_bank), 32'd2);
        chk("midrst_wr_frames", 32'(wr_frames), 32'd0);
        push(1'b1, 1'b1, 0, 2, 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        tick(GAP);
        fval = 1'b0;
        tick(GAP);
        chk("partial_wr_frames", 32'(wr_frames), 32'd0);
        chk("partial_wr_bank", 32'(wr_bank), 32'd0);
        frame(1, 2, 1'b0, 1, 0, 0);
        tick(GAP);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        chk("bank_invariant_violations", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
